// File: rtl/rx_ts_prepend.sv
// rtl/rx_ts_prepend.sv - store-and-forward frame buffer that prepends the start-of-packet timestamp
module rx_ts_prepend #(
  parameter int TS_WIDTH        = 64,
  parameter int FIFO_ADDR_WIDTH = 11,
  parameter int TS_FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TS_WIDTH-1:0] ts,
  input  logic                s_start_packet,
  input  logic [7:0]          s_axis_tdata,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tuser,
  output logic [7:0]          m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  output logic                status_drop,
  output logic                status_busy
);

  localparam int NB  = TS_WIDTH / 8;
  localparam int TSA = $clog2(TS_FIFO_DEPTH);
  localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [FIFO_ADDR_WIDTH:0] FIFO_SIZE = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  logic [9:0]               mem    [2**FIFO_ADDR_WIDTH];
  logic [TS_WIDTH-1:0]      ts_mem [TS_FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH:0] wr_ptr, commit_ptr, rd_ptr, wr_base;
  logic [TSA:0]             ts_wr, ts_rd;
  logic [TS_WIDTH-1:0]      ts_reg, hdr_sr, push_val, ts_head;
  logic                     ts_held_valid, drop_mode;
  logic                     drop_eff, held_eff, fifo_full, ts_full, ts_empty;
  logic                     wr_en, commit, overflow, drop_now;
  logic [CW-1:0]            byte_cnt;
  logic [9:0]               rd_word;
  logic                     hs, avail;
  logic                     ts_pop, load_hdr, shift_hdr, load_pay, go_empty;
  state_t                   state, state_next;

  // A start strobe takes effect in its own cycle, so a byte arriving with it belongs to the new frame.
  assign wr_base   = s_start_packet ? commit_ptr : wr_ptr;
  assign drop_eff  = s_start_packet ? 1'b0 : drop_mode;
  assign held_eff  = s_start_packet | ts_held_valid;
  assign push_val  = s_start_packet ? ts : ts_reg;
  assign fifo_full = (wr_base - rd_ptr) == FIFO_SIZE;
  assign ts_empty  = (ts_wr == ts_rd);
  assign ts_full   = (ts_wr[TSA] != ts_rd[TSA]) && (ts_wr[TSA-1:0] == ts_rd[TSA-1:0]);
  assign overflow  = s_axis_tvalid & ~drop_eff & fifo_full;
  assign wr_en     = s_axis_tvalid & ~drop_eff & ~fifo_full;
  assign commit    = wr_en & s_axis_tlast & held_eff & ~ts_full;
  assign drop_now  = (s_start_packet & (wr_ptr != commit_ptr)) | overflow |
                     (wr_en & s_axis_tlast & ~commit);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_base[FIFO_ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tdata};
    if (commit) ts_mem[ts_wr[TSA-1:0]] <= push_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      ts_wr         <= '0;
      ts_reg        <= '0;
      ts_held_valid <= 1'b0;
      drop_mode     <= 1'b0;
      status_drop   <= 1'b0;
    end else begin
      if (s_start_packet) begin
        ts_reg    <= ts;
        drop_mode <= 1'b0;
      end
      if (commit) ts_held_valid <= 1'b0;
      else if (s_start_packet) ts_held_valid <= 1'b1;
      if (overflow) begin
        wr_ptr    <= commit_ptr;
        drop_mode <= 1'b1;
      end else if (wr_en) begin
        wr_ptr <= (!s_axis_tlast || commit) ? wr_base + 1'b1 : commit_ptr;
      end else begin
        wr_ptr <= wr_base;
      end
      if (commit) begin
        commit_ptr <= wr_base + 1'b1;
        ts_wr      <= ts_wr + 1'b1;
      end
      status_drop <= drop_now;
    end
  end

  // Readers only ever see committed bytes, so a frame is always fully present once its header starts.
  assign hs      = m_axis_tvalid & m_axis_tready;
  assign avail   = (rd_ptr != commit_ptr);
  assign rd_word = mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]];
  assign ts_head = ts_mem[ts_rd[TSA-1:0]];

  always_comb begin
    state_next = state;
    ts_pop     = 1'b0;
    load_hdr   = 1'b0;
    shift_hdr  = 1'b0;
    load_pay   = 1'b0;
    go_empty   = 1'b0;
    case (state)
      IDLE: begin
        if (!ts_empty) begin
          load_hdr   = 1'b1;
          state_next = HEADER;
        end
      end
      HEADER: begin
        if (hs) begin
          if (byte_cnt == '0) begin
            ts_pop     = 1'b1;
            state_next = PAYLOAD;
            if (avail) load_pay = 1'b1;
            else go_empty = 1'b1;
          end else begin
            shift_hdr = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (hs && m_axis_tlast) begin
          if (!ts_empty) begin
            load_hdr   = 1'b1;
            state_next = HEADER;
          end else begin
            go_empty   = 1'b1;
            state_next = IDLE;
          end
        end else if (hs || !m_axis_tvalid) begin
          if (avail) load_pay = 1'b1;
          else go_empty = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      ts_rd         <= '0;
      hdr_sr        <= '0;
      byte_cnt      <= '0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      state <= state_next;
      if (ts_pop) ts_rd <= ts_rd + 1'b1;
      if (load_hdr) begin
        m_axis_tdata  <= ts_head[TS_WIDTH-1 -: 8];
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= 1'b0;
        m_axis_tuser  <= 1'b0;
        hdr_sr        <= ts_head << 8;
        byte_cnt      <= CW'(NB - 1);
      end else if (shift_hdr) begin
        m_axis_tdata <= hdr_sr[TS_WIDTH-1 -: 8];
        hdr_sr       <= hdr_sr << 8;
        byte_cnt     <= byte_cnt - 1'b1;
      end else if (load_pay) begin
        m_axis_tdata  <= rd_word[7:0];
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= rd_word[9];
        m_axis_tuser  <= rd_word[9] & rd_word[8];
        rd_ptr        <= rd_ptr + 1'b1;
      end else if (go_empty) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        m_axis_tuser  <= 1'b0;
      end
    end
  end

  assign status_busy = (state != IDLE);

endmodule

// File: tb/tb_rx_ts_prepend.sv
// tb/tb_rx_ts_prepend.sv - directed bench for rx_ts_prepend (default buffer and a 64-byte buffer)
module tb_rx_ts_prepend;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] ts_in = 64'h0;
  logic        s_start = 1'b0, s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        m_tready;
  logic        tr_mode = 1'b0, tr_val = 1'b0, sel = 1'b0;

  logic [7:0] a_tdata, b_tdata, o_data;
  logic a_tvalid, a_tlast, a_tuser, a_drop, a_busy;
  logic b_tvalid, b_tlast, b_tuser, b_drop, b_busy;
  logic o_valid, o_last, o_user, o_drop;

  int n_checks = 0, n_fail = 0, cyc = 0, drop_cnt = 0, stall_viol = 0, stall_seen = 0;
  logic [9:0] got[$], exp[$], prev_word;
  int hs_cyc[$];
  logic prev_stall = 1'b0;

  rx_ts_prepend dut (
    .clk(clk), .rst_n(rst_n), .ts(ts_in), .s_start_packet(s_start),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser), .status_drop(a_drop), .status_busy(a_busy)
  );

  rx_ts_prepend #(.FIFO_ADDR_WIDTH(6)) dut_small (
    .clk(clk), .rst_n(rst_n), .ts(ts_in), .s_start_packet(s_start),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser), .status_drop(b_drop), .status_busy(b_busy)
  );

  assign o_data  = sel ? b_tdata  : a_tdata;
  assign o_valid = sel ? b_tvalid : a_tvalid;
  assign o_last  = sel ? b_tlast  : a_tlast;
  assign o_user  = sel ? b_tuser  : a_tuser;
  assign o_drop  = sel ? b_drop   : a_drop;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (tr_mode) m_tready = ~m_tready;
    else m_tready = tr_val;
  end

  // Output recorder: captures handshakes, drop pulses and stall stability for the selected instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      got.delete();
      hs_cyc.delete();
      drop_cnt = 0;
      stall_viol = 0;
      stall_seen = 0;
      prev_stall = 1'b0;
    end else begin
      if (o_valid && m_tready) begin
        got.push_back({o_user, o_last, o_data});
        hs_cyc.push_back(cyc);
      end
      if (o_drop) drop_cnt++;
      if (prev_stall && (!o_valid || {o_user, o_last, o_data} != prev_word)) stall_viol++;
      prev_stall = o_valid && !m_tready;
      prev_word = {o_user, o_last, o_data};
      if (prev_stall) stall_seen++;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic add_exp(input logic [63:0] t, input int len, input logic [7:0] base, input logic user);
    for (int b = 0; b < 8; b++) exp.push_back({2'b00, t[63-8*b -: 8]});
    for (int i = 0; i < len; i++)
      exp.push_back({user && (i == len - 1), i == len - 1, 8'(base + i)});
  endtask

  task automatic send_frame(input int len, input logic [63:0] t, input logic [7:0] base,
                            input logic user, input logic with_last, output int last_cyc);
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      s_start  = (i == 0);
      ts_in    = (i == 0) ? t : ~t;
      s_tvalid = 1'b1;
      s_tdata  = 8'(base + i);
      s_tlast  = with_last && (i == len - 1);
      s_tuser  = with_last && (i == len - 1) && user;
      last_cyc = cyc;
    end
    @(posedge clk);
    #1;
    s_start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 7;
    if (a_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", a_tvalid); end
    if (a_tlast  !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b expected 0", a_tlast); end
    if (a_tuser  !== 1'b0) begin n_fail++; $display("FAIL reset_tuser: got %b expected 0", a_tuser); end
    if (a_tdata  !== 8'h00) begin n_fail++; $display("FAIL reset_tdata: got %h expected 00", a_tdata); end
    if (a_drop   !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b expected 0", a_drop); end
    if (a_busy   !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    if (b_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_small_tvalid: got %b expected 0", b_tvalid); end
  endtask

  task automatic test_single();
    int lc;
    sel = 1'b0; tr_mode = 1'b0; tr_val = 1'b1;
    do_reset();
    add_exp(64'h0123456789ABCDEF, 64, 8'h00, 1'b0);
    send_frame(64, 64'h0123456789ABCDEF, 8'h00, 1'b0, 1'b1, lc);
    for (int i = 0; i < 400 && got.size() < 72; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    n_checks++;
    if (got.size() != 72) begin n_fail++; $display("FAIL single_count: got %0d expected 72", got.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_fail++; $display("FAIL single_byte%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 10'h0, exp[i]);
      end
    end
    n_checks += 3;
    if (drop_cnt != 0) begin n_fail++; $display("FAIL single_drop: got %0d expected 0", drop_cnt); end
    if (hs_cyc.size() < 72 || hs_cyc[0] != lc + 2) begin
      n_fail++; $display("FAIL single_latency: got cycle %0d expected %0d", (hs_cyc.size() > 0) ? hs_cyc[0] : -1, lc + 2);
    end
    if (hs_cyc.size() < 72 || hs_cyc[71] - hs_cyc[0] != 71) begin
      n_fail++; $display("FAIL single_rate: got span %0d expected 71", (hs_cyc.size() >= 72) ? hs_cyc[71] - hs_cyc[0] : -1);
    end
  endtask

  task automatic test_stall_tuser();
    int lc;
    sel = 1'b0; tr_mode = 1'b1;
    do_reset();
    add_exp(64'h0123456789ABCDEF, 64, 8'h00, 1'b1);
    send_frame(64, 64'h0123456789ABCDEF, 8'h00, 1'b1, 1'b1, lc);
    for (int i = 0; i < 600 && got.size() < 72; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    tr_mode = 1'b0;
    n_checks++;
    if (got.size() != 72) begin n_fail++; $display("FAIL stall_count: got %0d expected 72", got.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_fail++; $display("FAIL stall_byte%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 10'h0, exp[i]);
      end
    end
    n_checks += 3;
    if (stall_viol != 0) begin n_fail++; $display("FAIL stall_stability: got %0d changes expected 0", stall_viol); end
    if (stall_seen == 0) begin n_fail++; $display("FAIL stall_seen: got 0 stalled cycles expected >0"); end
    if (drop_cnt != 0) begin n_fail++; $display("FAIL stall_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_overflow();
    int lc;
    sel = 1'b1; tr_mode = 1'b0; tr_val = 1'b1;
    do_reset();
    add_exp(64'h1122334455667788, 10, 8'h80, 1'b0);
    send_frame(100, 64'hFFEEDDCCBBAA9988, 8'h00, 1'b0, 1'b1, lc);
    send_frame(10, 64'h1122334455667788, 8'h80, 1'b0, 1'b1, lc);
    for (int i = 0; i < 200 && got.size() < 18; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    n_checks += 2;
    if (got.size() != 18) begin n_fail++; $display("FAIL ovf_count: got %0d expected 18", got.size()); end
    if (drop_cnt != 1) begin n_fail++; $display("FAIL ovf_drop: got %0d expected 1", drop_cnt); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_fail++; $display("FAIL ovf_byte%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 10'h0, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lc;
    logic [63:0] t;
    sel = 1'b0; tr_mode = 1'b0; tr_val = 1'b0;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      t = 64'h0F1E2D3C4B5A6970 + 64'(f) * 64'h0101010101010101;
      if (f < 4) add_exp(t, 60, 8'(f * 48), 1'b0);
      send_frame(60, t, 8'(f * 48), 1'b0, 1'b1, lc);
    end
    repeat (5) @(negedge clk);
    n_checks += 2;
    if (drop_cnt != 1) begin n_fail++; $display("FAIL b2b_drop: got %0d expected 1", drop_cnt); end
    if (got.size() != 0) begin n_fail++; $display("FAIL b2b_held: got %0d bytes expected 0", got.size()); end
    tr_val = 1'b1;
    for (int i = 0; i < 600 && got.size() < 272; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    n_checks += 2;
    if (got.size() != 272) begin n_fail++; $display("FAIL b2b_count: got %0d expected 272", got.size()); end
    if (hs_cyc.size() < 272 || hs_cyc[271] - hs_cyc[0] != 271) begin
      n_fail++; $display("FAIL b2b_gapless: got span %0d expected 271", (hs_cyc.size() >= 272) ? hs_cyc[271] - hs_cyc[0] : -1);
    end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 10'h0, exp[i]);
      end
    end
  endtask

  task automatic test_midframe();
    int lc;
    sel = 1'b0; tr_mode = 1'b0; tr_val = 1'b1;
    do_reset();
    add_exp(64'hCAFEBABE00112233, 30, 8'h40, 1'b0);
    send_frame(20, 64'h0000111122223333, 8'h00, 1'b0, 1'b0, lc);
    send_frame(30, 64'hCAFEBABE00112233, 8'h40, 1'b0, 1'b1, lc);
    for (int i = 0; i < 200 && got.size() < 38; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    n_checks += 2;
    if (got.size() != 38) begin n_fail++; $display("FAIL mid_count: got %0d expected 38", got.size()); end
    if (drop_cnt != 1) begin n_fail++; $display("FAIL mid_drop: got %0d expected 1", drop_cnt); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_fail++; $display("FAIL mid_byte%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 10'h0, exp[i]);
      end
    end
  endtask

  task automatic test_reset_payload();
    int lc;
    sel = 1'b0; tr_mode = 1'b0; tr_val = 1'b1;
    do_reset();
    send_frame(64, 64'h5555AAAA5555AAAA, 8'h10, 1'b0, 1'b1, lc);
    for (int i = 0; i < 200 && got.size() < 20; i++) @(negedge clk);
    #2;
    n_checks++;
    if (a_busy !== 1'b1) begin n_fail++; $display("FAIL rstp_busy_before: got %b expected 1", a_busy); end
    rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (a_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstp_tvalid: got %b expected 0", a_tvalid); end
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rstp_busy: got %b expected 0", a_busy); end
    do_reset();
    add_exp(64'h0BADF00D12345678, 10, 8'hC0, 1'b0);
    send_frame(10, 64'h0BADF00D12345678, 8'hC0, 1'b0, 1'b1, lc);
    for (int i = 0; i < 200 && got.size() < 18; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    n_checks += 2;
    if (got.size() != 18) begin n_fail++; $display("FAIL rstp_count: got %0d expected 18", got.size()); end
    if (drop_cnt != 0) begin n_fail++; $display("FAIL rstp_drop: got %0d expected 0", drop_cnt); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_fail++; $display("FAIL rstp_byte%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 10'h0, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall_tuser();
    test_overflow();
    test_back_to_back();
    test_midframe();
    test_reset_payload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
